// File: rtl/spm_seq_pkg.sv
// Shared definitions for the SPM sequencer: register offsets,
// CTRL/STATUS bit positions, FSM state type and a byte-select helper.
package spm_seq_pkg;

  localparam logic [7:0] OFF_MC      = 8'h00;
  localparam logic [7:0] OFF_MP      = 8'h04;
  localparam logic [7:0] OFF_CTRL    = 8'h08;
  localparam logic [7:0] OFF_STATUS  = 8'h0C;
  localparam logic [7:0] OFF_PROD_LO = 8'h10;
  localparam logic [7:0] OFF_PROD_HI = 8'h14;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RD_LO = 3'd3,
    S_RD_HI = 3'd4
  } state_t;

  function automatic logic [31:0] sel_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8]
                           : old_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/spm_seq_regs.sv
// Wishbone slave decode/ack, register file and sticky W1C status.
// Ports: wbs_* bus, busy/done_set/timeout_set/prod_*_we from FSM, mc/mp/go/irq out.
module spm_seq_regs
  import spm_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic        busy,
  input  logic        done_set,
  input  logic        timeout_set,
  input  logic        prod_lo_we,
  input  logic        prod_hi_we,
  input  logic [31:0] prod_in,
  output logic [31:0] mc,
  output logic [31:0] mp,
  output logic        go,
  output logic        irq
);

  logic [7:0]  off;
  logic        hit;
  logic        req;
  logic        wr;
  logic        wr_mc;
  logic        wr_mp;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        w1c_done;
  logic        w1c_tmo;
  logic        irq_en;
  logic        st_done;
  logic        st_tmo;
  logic [31:0] prod_lo;
  logic [31:0] prod_hi;
  logic [31:0] rdata;
  logic [31:0] dat_q;

  assign off = wbs_adr_i[7:0];
  assign hit = wbs_adr_i[31:8] == BASE_ADDR[31:8];
  // The !ack term keeps a held strobe from being taken twice.
  assign req = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign wr  = req & wbs_we_i;

  assign wr_mc   = wr & (off == OFF_MC);
  assign wr_mp   = wr & (off == OFF_MP);
  assign wr_ctrl = wr & (off == OFF_CTRL);
  assign wr_stat = wr & (off == OFF_STATUS);

  assign go = wr_ctrl & wbs_sel_i[0]
            & wbs_dat_i[CTRL_GO];

  assign w1c_done = wr_stat & wbs_dat_i[ST_DONE];
  assign w1c_tmo  = wr_stat & wbs_dat_i[ST_TIMEOUT];

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      off == OFF_MC:      rdata = mc;
      off == OFF_MP:      rdata = mp;
      off == OFF_CTRL:    rdata[CTRL_IRQ_EN] = irq_en;
      off == OFF_STATUS: begin
        rdata[ST_BUSY]    = busy;
        rdata[ST_DONE]    = st_done;
        rdata[ST_TIMEOUT] = st_tmo;
      end
      off == OFF_PROD_LO: rdata = prod_lo;
      off == OFF_PROD_HI: rdata = prod_hi;
      default:            rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wbs_ack_o <= 1'b0;
      dat_q     <= '0;
      mc        <= '0;
      mp        <= '0;
      irq_en    <= 1'b0;
      st_done   <= 1'b0;
      st_tmo    <= 1'b0;
      prod_lo   <= '0;
      prod_hi   <= '0;
    end else begin
      wbs_ack_o <= req;
      dat_q     <= req ? rdata : '0;
      if (wr_mc) begin
        mc <= sel_merge(mc, wbs_dat_i, wbs_sel_i);
      end
      if (wr_mp) begin
        mp <= sel_merge(mp, wbs_dat_i, wbs_sel_i);
      end
      if (wr_ctrl && wbs_sel_i[0]) begin
        irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      end
      // A set arriving with a clear wins.
      st_done <= done_set | (st_done & ~w1c_done);
      st_tmo  <= timeout_set | (st_tmo & ~w1c_tmo);
      if (prod_lo_we) begin
        prod_lo <= prod_in;
      end
      if (prod_hi_we) begin
        prod_hi <= prod_in;
      end
    end
  end

  assign wbs_dat_o = dat_q;
  assign irq = irq_en & (st_done | st_tmo);

endmodule

// File: rtl/spm_seq_ctrl.sv
// SPM sequencer top: start pulse, bounded done wait, two-half product readout.
// Ports: Wishbone slave, spm_mc/mp/start/prod_sel to SPM, spm_done/prod from SPM, irq.
module spm_seq_ctrl
  import spm_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          TIMEOUT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [31:0] spm_mc,
  output logic [31:0] spm_mp,
  output logic        spm_start,
  input  logic        spm_done,
  output logic        spm_prod_sel,
  input  logic [31:0] spm_prod,
  output logic        irq
);

  state_t               state;
  logic [TIMEOUT_W-1:0] cnt;
  logic [31:0]          mc;
  logic [31:0]          mp;
  logic                 go;
  logic                 busy;
  logic                 at_limit;
  logic                 done_set;
  logic                 timeout_set;
  logic                 prod_lo_we;
  logic                 prod_hi_we;

  assign busy      = state != S_IDLE;
  assign spm_start = state == S_START;
  assign spm_prod_sel = state == S_RD_HI;

  assign at_limit = cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  assign prod_lo_we  = state == S_RD_LO;
  assign prod_hi_we  = state == S_RD_HI;
  assign done_set    = state == S_RD_HI;
  assign timeout_set = (state == S_WAIT)
                     & ~spm_done & at_limit;

  spm_seq_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_ack_o   (wbs_ack_o),
    .busy        (busy),
    .done_set    (done_set),
    .timeout_set (timeout_set),
    .prod_lo_we  (prod_lo_we),
    .prod_hi_we  (prod_hi_we),
    .prod_in     (spm_prod),
    .mc          (mc),
    .mp          (mp),
    .go          (go),
    .irq         (irq)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      spm_mc <= '0;
      spm_mp <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          // Shadows freeze operands for the whole run.
          if (go) begin
            state  <= S_START;
            spm_mc <= mc;
            spm_mp <= mp;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + TIMEOUT_W'(1);
          if (spm_done) begin
            state <= S_RD_LO;
          end else if (at_limit) begin
            state <= S_IDLE;
          end
        end
        S_RD_LO: state <= S_RD_HI;
        S_RD_HI: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spm_seq_ctrl.md
Name: spm_seq_ctrl

Overview:
- Wishbone-slave sequencer for the serial-parallel multiplier (SPM) in user_proj_top; sits between the Caravel Wishbone bus and the SPM start/done/prod_sel interface.
- Software writes the multiplicand and multiplier, then sets GO. The block pulses start, waits for done with a timeout, and reads the 64-bit product out in two 32-bit halves via prod_sel.
- It then exposes the product and sticky status to software.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base; decode on wbs_adr_i[31:8] == BASE_ADDR[31:8].
- TIMEOUT_CYCLES, 256, max cycles in WAIT before abort.
- TIMEOUT_W, 16, timeout counter width; TIMEOUT_CYCLES must be < 2**TIMEOUT_W.

Ports:
- clk  input  1  system clock (wb_clk_i).
- rst  input  1  synchronous, active-low reset.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte selects; applied to MC, MP and CTRL writes.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_dat_o  output  32  read data.
- wbs_ack_o  output  1  single-cycle acknowledge.
- spm_mc  output  32  multiplicand to SPM (shadow register).
- spm_mp  output  32  multiplier to SPM (shadow register).
- spm_start  output  1  one-cycle start pulse.
- spm_done  input  1  SPM product valid (level); cleared by the next start.
- spm_prod_sel  output  1  0 = low half, 1 = high half of the product.
- spm_prod  input  32  selected product half, combinational from prod_sel.
- irq  output  1  IRQ_EN & (DONE | TIMEOUT).

Behaviour:
- Reset (rst == 0 at a clk edge): every output 0; FSM to IDLE; all registers, shadows and counter 0. Applies mid-operation; no start pulse after reset is released.
- Register map (byte offsets):
  - 0x00 MC, RW.
  - 0x04 MP, RW.
  - 0x08 CTRL: bit0 GO (write-only, reads 0), bit1 IRQ_EN (RW).
  - 0x0C STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 TIMEOUT (sticky, W1C).
  - 0x10 PROD_LO, RO.
  - 0x14 PROD_HI, RO.
  - Other offsets in the decoded window: read 0, writes ignored, still acked.
- Wishbone:
  - Request (cyc & stb & decode & !ack) sampled at edge T; write commits at T; wbs_ack_o high during cycle T+1 only.
  - wbs_dat_o is valid with ack and reflects register values before edge T.
  - wbs_dat_o is 0 when ack is low.
- FSM states:
  - IDLE: GO write with wbs_dat_i[0] and sel[0] set -> START; MC/MP copied to the spm_mc/spm_mp shadows on the same edge.
  - START: spm_start = 1 for exactly one cycle; counter cleared -> WAIT.
  - WAIT: counter increments each cycle. spm_done = 1 -> RD_LO. Counter == TIMEOUT_CYCLES-1 without done -> set TIMEOUT, go IDLE, PROD regs unchanged.
  - RD_LO: prod_sel = 0; PROD_LO <= spm_prod -> RD_HI.
  - RD_HI: prod_sel = 1; PROD_HI <= spm_prod; set DONE -> IDLE.
- Timing:
  - BUSY = (state != IDLE).
  - GO acked in cycle 1, spm_start high in cycle 1.
  - If done is first high in cycle N, DONE is set and BUSY clears from cycle N+3.
- GO while BUSY: ignored, no error flag. MC/MP writes while BUSY update the registers only; the shadows hold.
- W1C clear in the same cycle a flag is set: the set wins.
- spm_done high in the START cycle is ignored; done is sampled only in WAIT.
- prod_sel is 0 outside RD_HI.

Decomposition:
- Package spm_seq_pkg holds:
  - the register offset localparams;
  - the STATUS/CTRL bit indices;
  - the state enum (IDLE, START, WAIT, RD_LO, RD_HI).
- One sub-module, spm_seq_regs, holds the Wishbone decode/ack, the register file and the W1C logic. It exports a go pulse and takes done_set/timeout_set/prod captures from the FSM in the top.

Test Plan:
- MC = 0x3, MP = 0x5, GO; SPM model done after 64 cycles -> single spm_start pulse; prod_sel goes 0 then 1; PROD_LO = 0x0000000F, PROD_HI = 0; STATUS = 0x2.
- MC = MP = 0xFFFFFFFF -> PROD_HI = 0xFFFFFFFE, PROD_LO = 0x00000001; with IRQ_EN = 1, irq rises with DONE; W1C 0x2 -> irq = 0.
- Model never asserts done -> TIMEOUT set exactly 256 cycles after WAIT entry; BUSY = 0; PROD regs unchanged; STATUS = 0x4.
- Second GO and a MC = 0x7 write during WAIT -> no extra spm_start; spm_mc holds the old value; MC readback = 0x7; result uses the old MC.
- rst low for one cycle in WAIT -> all outputs 0 and STATUS = 0 next cycle; a later done from the model is ignored; no spm_start until a new GO.
- W1C DONE issued in the RD_HI cycle -> DONE reads 1 afterwards; unmapped offset 0x20 reads 0 with a single-cycle ack.
